router_fsm_ctrl: RTL and testbench
==================================

// Module: router_fsm_ctrl
// PURPOSE
//  Packet-sequencing controller for the 3-port router input side. Decodes the header address,
//  waits for the target FIFO to drain, then drives the load/full/parity strobes that sequence
//  router_reg. Also drives the write enable toward the FIFO block and busy back to the source.
//  Moore FSM; all outputs are decoded from the registered state only.
// PARAMETERS
//  NPORTS  3  number of output ports/FIFOs; fixed at 3, and address 2'b11 is invalid
//  ADDR_W  2  header address field width, taken from datain[1:0]
// PORTS
//  clk              in   1  system clock, rising edge
//  reset            in   1  synchronous, active-high reset
//  packet_valid     in   1  source is presenting packet bytes
//  datain           in   2  header address bits (datain[1:0]), sampled in DECODE_ADDRESS
//  fifo_full        in   1  full flag of the currently addressed FIFO
//  fifo_empty       in   3  per-port FIFO empty flags
//  soft_reset       in   3  per-port FIFO read-timeout soft resets
//  parity_done      in   1  from router_reg: parity byte has been captured
//  low_packet_valid in   1  from router_reg: packet_valid fell while in full handling
//  port_addr        out  2  address latched at header acceptance
//  detect_add       out  1  state==DECODE_ADDRESS
//  lfd_state        out  1  state==LOAD_FIRST_DATA
//  ld_state         out  1  state==LOAD_DATA
//  laf_state        out  1  state==LOAD_AFTER_FULL
//  full_state       out  1  state==FIFO_FULL_STATE
//  rst_int_reg      out  1  state==CHECK_PARITY_ERROR
//  write_enb_reg    out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
//  busy             out  1  state in {LFD, LOAD_PARITY, FFS, LAF, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR}
// BEHAVIOUR
//  - Reset:
//    - state <= DECODE_ADDRESS and port_addr <= 2'b00.
//    - Outputs after reset: detect_add=1; all other outputs 0.
//    - Reset has priority over every transition, including mid-packet.
//  - DA=DECODE_ADDRESS:
//    - Acceptance condition: packet_valid && datain!=2'b11.
//    - On acceptance: port_addr <= datain.
//    - If fifo_empty[datain]=1 -> LFD; otherwise -> WTE.
//    - datain==2'b11 or !packet_valid -> stay in DA; port_addr is unchanged.
//  - LFD=LOAD_FIRST_DATA: -> LD unconditionally after 1 cycle (header write).
//  - LD=LOAD_DATA:
//    - fifo_full -> FFS.
//    - else !packet_valid -> LP.
//    - else stay. fifo_full wins if it coincides with the drop of packet_valid.
//  - LP=LOAD_PARITY: -> CPE unconditionally.
//  - FFS=FIFO_FULL_STATE: !fifo_full -> LAF; else stay. write_enb_reg=0 here.
//  - LAF=LOAD_AFTER_FULL:
//    - parity_done -> DA.
//    - else low_packet_valid -> LP.
//    - else -> LD.
//  - CPE=CHECK_PARITY_ERROR: fifo_full -> FFS; else -> DA.
//  - WTE=WAIT_TILL_EMPTY: fifo_empty[port_addr] -> LFD; else stay.
//  - Soft reset:
//    - soft_reset[port_addr]=1 in any state other than DA -> DA next cycle.
//    - It has priority over all other transitions except reset.
//    - soft_reset of a non-addressed port is ignored.
//  - Latency and encoding:
//    - Header acceptance to first write_enb_reg: 2 cycles when the FIFO is empty.
//    - Output strobes are glitch-free registered-state decodes.
//    - Illegal state encodings -> DA.
// TESTING
//  - Reset: hold reset=1 for 2 clk -> detect_add=1, busy=0, write_enb_reg=0, port_addr=0.
//  - Normal packet, address 2'b10, fifo_empty=3'b111, 8 payload bytes:
//    -> DA, LFD, LD x8, LP, CPE, DA.
//    -> write_enb_reg high for 9 cycles plus the LFD header path; rst_int_reg pulses 1 cycle.
//  - Address 2'b01 with fifo_empty[1]=0 for 5 cycles -> busy=1 and stays in WTE for 5 cycles,
//    then LFD on the cycle after fifo_empty[1]=1.
//  - fifo_full=1 for 3 cycles mid-payload -> FFS held for 3 cycles with write_enb_reg=0,
//    then LAF; with low_packet_valid=0 -> LD.
//  - Header datain=2'b11 with packet_valid=1 -> remains in DA; port_addr is not updated.
//  - soft_reset[2]=1 during LD for port 2 -> DA next cycle; soft_reset[0] pulse is ignored.

Source files
------------

// File: rtl/router_fsm_ctrl_if.sv
// Signal bundle between the packet source/router_reg/FIFO block and the input-side
// sequencing controller. master drives the controller inputs; slave is the controller.
interface router_fsm_ctrl_if #(
    parameter int NPORTS = 3,
    parameter int ADDR_W = 2
);
    logic              packet_valid;
    logic [ADDR_W-1:0] datain;
    logic              fifo_full;
    logic [NPORTS-1:0] fifo_empty;
    logic [NPORTS-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;

    logic [ADDR_W-1:0] port_addr;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;

    modport master (
        output packet_valid, datain, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  port_addr, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy
    );

    modport slave (
        input  packet_valid, datain, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output port_addr, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy
    );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Input-side packet sequencing controller for the 3-port router: decodes the header
// address, waits for the target FIFO to drain and strobes router_reg. Moore outputs only.
module router_fsm_ctrl (
    input  logic              clk,
    input  logic              reset,
    router_fsm_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] addr_q;
    logic       accept;
    logic [3:0] empty_ext;
    logic [3:0] soft_ext;

    // Padding to four entries keeps the address-indexed lookups in range for 2'b11.
    assign empty_ext = {1'b0, bus.fifo_empty};
    assign soft_ext  = {1'b0, bus.soft_reset};
    assign accept    = (state == DECODE_ADDRESS) && bus.packet_valid && (bus.datain != 2'b11);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'b00;
        end else begin
            state <= state_nxt;
            if (accept) addr_q <= bus.datain;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (state != DECODE_ADDRESS && soft_ext[addr_q]) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (accept) state_nxt = empty_ext[bus.datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA:
                    if (bus.fifo_full)          state_nxt = FIFO_FULL_STATE;
                    else if (!bus.packet_valid) state_nxt = LOAD_PARITY;
                LOAD_PARITY:     state_nxt = CHECK_PARITY_ERROR;
                FIFO_FULL_STATE:
                    if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (bus.parity_done)           state_nxt = DECODE_ADDRESS;
                    else if (bus.low_packet_valid) state_nxt = LOAD_PARITY;
                    else                           state_nxt = LOAD_DATA;
                CHECK_PARITY_ERROR:
                    state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:
                    if (empty_ext[addr_q]) state_nxt = LOAD_FIRST_DATA;
                default:         state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.port_addr     = addr_q;
    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                               (state == LOAD_AFTER_FULL);
    assign bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: directed packet scenarios plus random
// traffic, every cycle compared against a phase-level model of the packet sequencer.
module tb_router_fsm_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_fsm_ctrl_if bus ();
    router_fsm_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef enum int {P_HDR, P_FIRST, P_BODY, P_PAR, P_STALL, P_RESUME, P_CHK, P_WAIT} phase_t;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
    } stim_t;

    int     total = 0;
    int     bad   = 0;
    phase_t ph    = P_HDR;
    int     addr  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(logic pv, logic [1:0] din, logic ff, logic [2:0] fe,
                                 logic [2:0] sr, logic pd, logic lpv, logic rst);
        stim_t s;
        s.pv = pv; s.din = din; s.ff = ff; s.fe = fe; s.sr = sr;
        s.pd = pd; s.lpv = lpv; s.rst = rst;
        return s;
    endfunction

    // Expected strobe word {port_addr, detect, lfd, ld, laf, full, rst_int, we, busy}.
    function automatic logic [9:0] expect_word(phase_t p, int a);
        logic writing, idle_or_body;
        writing      = (p inside {P_BODY, P_PAR, P_RESUME});
        idle_or_body = (p inside {P_HDR, P_BODY});
        return {a[1:0], p == P_HDR, p == P_FIRST, p == P_BODY, p == P_RESUME,
                p == P_STALL, p == P_CHK, writing, !idle_or_body};
    endfunction

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic drive(input stim_t s);
        phase_t nph;
        int     na;
        @(negedge clk);
        reset                = s.rst;
        bus.packet_valid     = s.pv;
        bus.datain           = s.din;
        bus.fifo_full        = s.ff;
        bus.fifo_empty       = s.fe;
        bus.soft_reset       = s.sr;
        bus.parity_done      = s.pd;
        bus.low_packet_valid = s.lpv;
        nph = ph;
        na  = addr;
        if (s.rst) begin
            nph = P_HDR; na = 0;
        end else if (ph != P_HDR && addr < 3 && s.sr[addr]) begin
            nph = P_HDR;
        end else begin
            case (ph)
                P_HDR: if (s.pv && s.din != 2'd3) begin
                    na  = s.din;
                    nph = s.fe[s.din] ? P_FIRST : P_WAIT;
                end
                P_FIRST:  nph = P_BODY;
                P_BODY:   nph = s.ff ? P_STALL : (!s.pv ? P_PAR : P_BODY);
                P_PAR:    nph = P_CHK;
                P_STALL:  nph = s.ff ? P_STALL : P_RESUME;
                P_RESUME: nph = s.pd ? P_HDR : (s.lpv ? P_PAR : P_BODY);
                P_CHK:    nph = s.ff ? P_STALL : P_HDR;
                P_WAIT:   nph = s.fe[addr] ? P_FIRST : P_WAIT;
                default:  nph = P_HDR;
            endcase
        end
        @(posedge clk);
        #1;
        ph   = nph;
        addr = na;
        check("strobes", {bus.port_addr, bus.detect_add, bus.lfd_state, bus.ld_state,
                          bus.laf_state, bus.full_state, bus.rst_int_reg,
                          bus.write_enb_reg, bus.busy}, expect_word(ph, addr));
    endtask

    int we_cnt, ri_cnt, busy_cnt, full_cnt, we_in_full;

    initial begin
        drive(mk(0, 0, 0, 3'b111, 0, 0, 0, 1));
        drive(mk(0, 0, 0, 3'b111, 0, 0, 0, 1));
        check("rst_detect", bus.detect_add, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_we", bus.write_enb_reg, 0);
        check("rst_addr", bus.port_addr, 0);

        // Normal packet to port 2, eight payload bytes.
        we_cnt = 0; ri_cnt = 0;
        drive(mk(1, 2, 0, 3'b111, 0, 0, 0, 0));
        we_cnt += bus.write_enb_reg; ri_cnt += bus.rst_int_reg;
        check("hdr_to_lfd", bus.lfd_state, 1);
        for (int i = 0; i < 8; i++) begin
            drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
            we_cnt += bus.write_enb_reg; ri_cnt += bus.rst_int_reg;
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 3'b111, 0, 0, 0, 0));
            we_cnt += bus.write_enb_reg; ri_cnt += bus.rst_int_reg;
        end
        check("pkt_we_cycles", we_cnt, 9);
        check("pkt_rst_int", ri_cnt, 1);
        check("pkt_back_da", bus.detect_add, 1);
        check("pkt_addr", bus.port_addr, 2);

        // Port 1 not empty for five cycles.
        busy_cnt = 0;
        drive(mk(1, 1, 0, 3'b101, 0, 0, 0, 0));
        busy_cnt += bus.busy;
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 0, 0, 3'b101, 0, 0, 0, 0));
            busy_cnt += bus.busy;
        end
        check("wte_busy_cycles", busy_cnt, 5);
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        check("wte_to_lfd", bus.lfd_state, 1);
        for (int i = 0; i < 4; i++) drive(mk(0, 0, 0, 3'b111, 0, 0, 0, 0));
        check("wte_pkt_done", bus.detect_add, 1);

        // fifo_full for three cycles mid-payload.
        full_cnt = 0; we_in_full = 0;
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 0, 1, 3'b111, 0, 0, 0, 0));
            full_cnt += bus.full_state; we_in_full += bus.write_enb_reg;
        end
        check("ffs_cycles", full_cnt, 3);
        check("ffs_no_we", we_in_full, 0);
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        check("ffs_to_laf", bus.laf_state, 1);
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        check("laf_to_ld", bus.ld_state, 1);
        for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 3'b111, 0, 0, 0, 0));

        // Invalid header address.
        drive(mk(1, 3, 0, 3'b111, 0, 0, 0, 0));
        drive(mk(1, 3, 0, 3'b111, 0, 0, 0, 0));
        check("bad_addr_da", bus.detect_add, 1);
        check("bad_addr_keep", bus.port_addr, 0);

        // Soft reset: other port ignored, addressed port aborts.
        drive(mk(1, 2, 0, 3'b111, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 3'b111, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 3'b111, 3'b001, 0, 0, 0));
        check("sr_other_ignored", bus.ld_state, 1);
        drive(mk(1, 0, 0, 3'b111, 3'b100, 0, 0, 0));
        check("sr_abort", bus.detect_add, 1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s.rst = ($urandom_range(0, 99) == 0);
            s.pv  = ($urandom_range(0, 9) < 7);
            s.din = 2'($urandom);
            s.ff  = ($urandom_range(0, 9) < 2);
            s.fe  = 3'($urandom);
            s.sr  = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
            s.pd  = ($urandom_range(0, 3) == 0);
            s.lpv = 1'($urandom);
            drive(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
